// File: rtl/pdm_decimator.sv
// Decodes a 1-bit PDM stream into an unsigned sample: the number of ones seen over
// each window of 2^DATA_BITS strobed bits, saturated to the output width.
//
// state | meaning
// IDLE  | counters held at zero, dout frozen, waiting for en
// ACQ   | counting strobed pdm bits, window closes every 2^DATA_BITS strobes
module pdm_decimator #(
    parameter int DATA_BITS = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 pdm_in,
    input  logic                 sample_en,
    input  logic                 en,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    output logic                 busy
);

    typedef enum logic {
        IDLE = 1'b0,
        ACQ  = 1'b1
    } state_t;

    localparam logic [DATA_BITS-1:0] WIN_LAST = '1;

    state_t               state_q, state_d;
    logic [1:0]           sync_q, sync_d;
    logic [DATA_BITS-1:0] win_cnt_q, win_cnt_d;
    logic [DATA_BITS:0]   ones_cnt_q, ones_cnt_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 dout_valid_q, dout_valid_d;

    logic                 pdm_s;
    logic [DATA_BITS:0]   ones_sum;

    assign pdm_s    = sync_q[1];
    assign ones_sum = ones_cnt_q + (DATA_BITS+1)'(pdm_s);
    assign sync_d   = {sync_q[0], pdm_in};

    always_comb begin
        state_d      = state_q;
        win_cnt_d    = win_cnt_q;
        ones_cnt_d   = ones_cnt_q;
        dout_d       = dout_q;
        dout_valid_d = 1'b0;
        case (state_q)
            IDLE: begin
                win_cnt_d  = '0;
                ones_cnt_d = '0;
                if (en) begin
                    state_d = ACQ;
                end
            end
            ACQ: begin
                if (!en) begin
                    // Dropping en abandons the partial window, even on its closing strobe.
                    state_d    = IDLE;
                    win_cnt_d  = '0;
                    ones_cnt_d = '0;
                end else if (sample_en) begin
                    win_cnt_d = win_cnt_q + DATA_BITS'(1);
                    if (win_cnt_q == WIN_LAST) begin
                        ones_cnt_d   = '0;
                        dout_valid_d = 1'b1;
                        dout_d       = ones_sum[DATA_BITS] ? WIN_LAST : ones_sum[DATA_BITS-1:0];
                    end else begin
                        ones_cnt_d = ones_sum;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            sync_q       <= '0;
            win_cnt_q    <= '0;
            ones_cnt_q   <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            sync_q       <= sync_d;
            win_cnt_q    <= win_cnt_d;
            ones_cnt_q   <= ones_cnt_d;
            dout_q       <= dout_d;
            dout_valid_q <= dout_valid_d;
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign busy       = (state_q == ACQ);

endmodule

// File: tb/tb_pdm_decimator.sv
// Randomized scoreboard bench for pdm_decimator: a list-based window model predicts
// every dout_valid (value and cycle) and a negedge monitor checks what the DUT shows.
module tb_pdm_decimator;

    localparam int DB  = 8;
    localparam int WIN = 1 << DB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          pdm_in = 1'b0;
    logic          sample_en = 1'b0;
    logic          en = 1'b0;
    logic [DB-1:0] dout;
    logic          dout_valid;
    logic          busy;

    pdm_decimator #(.DATA_BITS(DB)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .pdm_in     (pdm_in),
        .sample_en  (sample_en),
        .en         (en),
        .dout       (dout),
        .dout_valid (dout_valid),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int val;
        int cyc;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_err = 0;
    int   cyc = 0;

    // reference model state
    bit   m_acq = 0;
    bit   m_s1 = 0, m_s2 = 0;
    int   m_bits[$];
    bit   lb_check = 0;
    int   lb_din = 0;

    task automatic chk(input string name, input longint act, input longint exp_v);
        n_checks++;
        if (act != exp_v) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp_v, cyc);
        end
    endtask

    // Window model: collect the strobed, synchronised bits and sum a full window.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_acq = 0;
            m_s1  = 0;
            m_s2  = 0;
            m_bits.delete();
            sb.delete();
        end else begin
            int sum;
            cyc++;
            if (!m_acq) begin
                if (en) begin
                    m_acq = 1;
                    m_bits.delete();
                end
            end else if (!en) begin
                m_acq = 0;
                m_bits.delete();
            end else if (sample_en) begin
                m_bits.push_back(int'(m_s2));
                if (m_bits.size() == WIN) begin
                    sum = 0;
                    foreach (m_bits[i]) sum += m_bits[i];
                    sb.push_back('{val: (sum > WIN - 1) ? WIN - 1 : sum, cyc: cyc});
                    m_bits.delete();
                end
            end
            m_s2 = m_s1;
            m_s1 = pdm_in;
        end
    end

    logic [DB-1:0] last_dout = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            last_dout = '0;
        end else begin
            chk("busy", busy, m_acq);
            if (dout_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_valid", 1, 0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("dout", dout, e.val);
                    chk("valid_cycle", cyc, e.cyc);
                end
                if (lb_check) begin
                    chk("loopback_range", ((int'(dout) >= lb_din - 1) && (int'(dout) <= lb_din + 1)), 1);
                end
                last_dout = dout;
            end else begin
                chk("dout_stable", dout, last_dout);
            end
        end
    end

    task automatic step(input logic e, input logic se, input logic p);
        @(posedge clk);
        #1;
        en        = e;
        sample_en = se;
        pdm_in    = p;
    endtask

    initial begin
        int acc;
        // reset state
        #3;
        chk("rst_dout", dout, 0);
        chk("rst_valid", dout_valid, 0);
        chk("rst_busy", busy, 0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // all ones: saturated full-scale output
        for (int i = 0; i < 2 * WIN + 10; i++) step(1, 1, 1);
        step(0, 0, 0);
        repeat (3) step(0, 0, 0);

        // alternating 1,0: half scale
        for (int i = 0; i < 2 * WIN + 10; i++) step(1, 1, i[0] == 0);
        repeat (4) step(0, 0, 0);

        // sparse strobe 1-in-16, all zeros
        for (int i = 0; i < 2 * WIN * 16 + 20; i++) step(1, (i % 16) == 0, 0);
        repeat (4) step(0, 0, 0);

        // en dropped mid-window, restored 10 clks later
        for (int i = 0; i < WIN + 100; i++) step(1, 1, $urandom_range(0, 3) == 0);
        repeat (10) step(0, 1, 1);
        for (int i = 0; i < WIN + 20; i++) step(1, 1, $urandom_range(0, 1));
        repeat (4) step(0, 0, 0);

        // random strobe gaps, random data, occasional single-cycle en drops
        for (int i = 0; i < 5000; i++)
            step($urandom_range(0, 299) != 0, $urandom_range(0, 2) != 0, $urandom_range(0, 1));

        // reset asserted mid-window
        for (int i = 0; i < 100; i++) step(1, 1, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_dout", dout, 0);
        chk("midrst_valid", dout_valid, 0);
        chk("midrst_busy", busy, 0);
        step(1, 1, 1);
        step(1, 1, 1);
        rst_n = 1'b1;
        for (int i = 0; i < WIN + 20; i++) step(1, 1, 1);
        repeat (4) step(0, 0, 0);

        // sigma-delta loopback with constant din
        lb_din = 100;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            acc += lb_din;
            step(0, 0, acc >= WIN);
            if (acc >= WIN) acc -= WIN;
        end
        lb_check = 1;
        for (int i = 0; i < 3 * WIN + 10; i++) begin
            acc += lb_din;
            step(1, 1, acc >= WIN);
            if (acc >= WIN) acc -= WIN;
        end
        lb_check = 0;
        repeat (6) step(0, 0, 0);

        chk("scoreboard_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
